// File: rtl/exu_flush_sched_swc_pkg.sv
// Shared definitions for the EXU flush scheduler: flush codes, grant bit positions and FSM states.
package exu_flush_sched_swc_pkg;

    localparam logic [1:0] FLUSH_NONE = 2'd0;
    localparam logic [1:0] FLUSH_JB   = 2'd1;
    localparam logic [1:0] FLUSH_TRAP = 2'd2;

    localparam int GNT_BR   = 0;
    localparam int GNT_JMP  = 1;
    localparam int GNT_TRAP = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_PH = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_REDIR   = 2'd3
    } flush_state_t;

endpackage

// File: rtl/exu_flush_prio_arb.sv
// Fixed-priority flush request arbiter (trap > jump > branch) producing a one-hot grant and flush code.
module exu_flush_prio_arb
    import exu_flush_sched_swc_pkg::*;
(
    input  logic       trap_req,
    input  logic       jmp_req,
    input  logic       br_req,
    output logic [2:0] grant,
    output logic [1:0] code
);

    always_comb begin
        grant = 3'b000;
        code  = FLUSH_NONE;
        if (trap_req) begin
            grant[GNT_TRAP] = 1'b1;
            code            = FLUSH_TRAP;
        end else if (jmp_req) begin
            grant[GNT_JMP] = 1'b1;
            code           = FLUSH_JB;
        end else if (br_req) begin
            grant[GNT_BR] = 1'b1;
            code          = FLUSH_JB;
        end
    end

endmodule

// File: rtl/exu_flush_sched_swc.sv
// Flush scheduler: accepts one flush request, aligns it to the core phase, stalls, then redirects.
// Optional perf counters are enabled by defining EXU_FLUSH_PERF_EN.
module exu_flush_sched_swc
    import exu_flush_sched_swc_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int FLUSH_CYC = 4,
    parameter int ISSUE_PH  = 1
) (
    input  logic            hclk,
    input  logic            hrst,
    input  logic [3:0]      cycle_cnt,
    input  logic            trap_req,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            jmp_req,
    input  logic [PC_W-1:0] jmp_pc,
    input  logic            br_req,
    input  logic [PC_W-1:0] br_pc,
    output logic            ack_trap,
    output logic            ack_jmp,
    output logic            ack_br,
    output logic            flush_stall,
    output logic [1:0]      flush_code,
    output logic            redirect_vld,
    output logic [PC_W-1:0] redirect_pc,
`ifdef EXU_FLUSH_PERF_EN
    output logic [15:0]     perf_flush_cnt,
    output logic [15:0]     perf_stall_cyc,
`endif
    output logic            busy
);

    generate
        if (FLUSH_CYC < 1 || FLUSH_CYC > 15) begin : g_bad_flush_cyc
            $error("exu_flush_sched_swc: FLUSH_CYC must be in 1..15");
        end
        if (ISSUE_PH < 1 || ISSUE_PH > 4) begin : g_bad_issue_ph
            $error("exu_flush_sched_swc: ISSUE_PH must be in 1..4");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

    flush_state_t    state;
    flush_state_t    state_nxt;
    logic [2:0]      grant;
    logic [1:0]      arb_code;
    logic [PC_W-1:0] win_pc;
    logic [PC_W-1:0] pc_q;
    logic [1:0]      code_q;
    logic [3:0]      cnt;
    logic            accept;
    logic            preempt;
    logic            phase_hit;

    exu_flush_prio_arb u_arb (
        .trap_req (trap_req),
        .jmp_req  (jmp_req),
        .br_req   (br_req),
        .grant    (grant),
        .code     (arb_code)
    );

    always_comb begin
        win_pc = br_pc;
        if (grant[GNT_TRAP]) begin
            win_pc = trap_pc;
        end else if (grant[GNT_JMP]) begin
            win_pc = jmp_pc;
        end
    end

    // cycle_cnt==0 (core in reset) can never match since ISSUE_PH is 1..4.
    assign phase_hit = (cycle_cnt == 4'(ISSUE_PH));
    assign preempt   = trap_req && (code_q == FLUSH_JB) &&
                       ((state == ST_WAIT_PH) || (state == ST_FLUSH));

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A trap preemption takes priority over the phase match or the end of stall that same cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant != 3'b000) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT_PH;
                end
            end
            ST_WAIT_PH: begin
                if (!preempt && phase_hit) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!preempt && (cnt == 4'd0)) begin
                    state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            ack_trap <= 1'b0;
            ack_jmp  <= 1'b0;
            ack_br   <= 1'b0;
        end else begin
            ack_trap <= (accept && grant[GNT_TRAP]) || preempt;
            ack_jmp  <= accept && grant[GNT_JMP];
            ack_br   <= accept && grant[GNT_BR];
        end
    end

    // Reloading cnt on preemption keeps flush_stall high with no gap for the new trap flush.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            code_q <= FLUSH_NONE;
            pc_q   <= '0;
            cnt    <= 4'd0;
        end else begin
            if (accept) begin
                code_q <= arb_code;
                pc_q   <= win_pc;
            end else if (preempt) begin
                code_q <= FLUSH_TRAP;
                pc_q   <= trap_pc;
            end else if (state == ST_REDIR) begin
                code_q <= FLUSH_NONE;
            end

            if (((state == ST_WAIT_PH) && (state_nxt == ST_FLUSH)) ||
                ((state == ST_FLUSH) && preempt)) begin
                cnt <= CNT_INIT;
            end else if ((state == ST_FLUSH) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign flush_stall  = (state == ST_FLUSH);
    assign redirect_vld = (state == ST_REDIR);
    assign redirect_pc  = redirect_vld ? pc_q : '0;
    assign flush_code   = busy ? code_q : FLUSH_NONE;

`ifdef EXU_FLUSH_PERF_EN
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            perf_flush_cnt <= 16'd0;
            perf_stall_cyc <= 16'd0;
        end else begin
            if (redirect_vld && (perf_flush_cnt != 16'hFFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
            if (flush_stall && (perf_stall_cyc != 16'hFFFF)) begin
                perf_stall_cyc <= perf_stall_cyc + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exu_flush_sched_swc.sv
// Directed bench for exu_flush_sched_swc (FLUSH_CYC=4, ISSUE_PH=1): table of single flushes plus corner sequences.
module tb_exu_flush_sched_swc;

    localparam int PC_W      = 32;
    localparam int FLUSH_CYC = 4;
    localparam int ISSUE_PH  = 1;

    logic            hclk = 1'b0;
    logic            hrst = 1'b1;
    logic [3:0]      cycle_cnt = 4'd0;
    logic            trap_req = 1'b0;
    logic [PC_W-1:0] trap_pc = '0;
    logic            jmp_req = 1'b0;
    logic [PC_W-1:0] jmp_pc = '0;
    logic            br_req = 1'b0;
    logic [PC_W-1:0] br_pc = '0;
    logic            ack_trap;
    logic            ack_jmp;
    logic            ack_br;
    logic            flush_stall;
    logic [1:0]      flush_code;
    logic            redirect_vld;
    logic [PC_W-1:0] redirect_pc;
    logic            busy;
`ifdef EXU_FLUSH_PERF_EN
    logic [15:0]     perf_flush_cnt;
    logic [15:0]     perf_stall_cyc;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit phase_run = 1'b0;

    always #5 hclk = ~hclk;

    exu_flush_sched_swc #(
        .PC_W      (PC_W),
        .FLUSH_CYC (FLUSH_CYC),
        .ISSUE_PH  (ISSUE_PH)
    ) dut (
        .hclk         (hclk),
        .hrst         (hrst),
        .cycle_cnt    (cycle_cnt),
        .trap_req     (trap_req),
        .trap_pc      (trap_pc),
        .jmp_req      (jmp_req),
        .jmp_pc       (jmp_pc),
        .br_req       (br_req),
        .br_pc        (br_pc),
        .ack_trap     (ack_trap),
        .ack_jmp      (ack_jmp),
        .ack_br       (ack_br),
        .flush_stall  (flush_stall),
        .flush_code   (flush_code),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
`ifdef EXU_FLUSH_PERF_EN
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cyc (perf_stall_cyc),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic        trap;
        logic        jmp;
        logic        br;
        logic [31:0] pc;
        logic [3:0]  phase;
        logic [2:0]  exp_ack;
        logic [1:0]  exp_code;
        int          exp_wait;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock; inputs (including the bench-driven phase counter) change 1ns after the edge.
    task automatic tick();
        @(posedge hclk);
        #1;
        if (phase_run) begin
            cycle_cnt = (cycle_cnt >= 4'd4) ? 4'd1 : cycle_cnt + 4'd1;
        end else begin
            cycle_cnt = 4'd0;
        end
    endtask

    task automatic apply_stimulus(input logic t, input logic j, input logic b, input logic [31:0] pc);
        trap_req = t;
        jmp_req  = j;
        br_req   = b;
        if (t) trap_pc = pc;
        if (j) jmp_pc  = pc;
        if (b) br_pc   = pc;
    endtask

    task automatic wait_phase(input logic [3:0] ph);
        int n = 0;
        while (cycle_cnt != ph && n < 8) begin
            tick();
            n++;
        end
        check_output("wait_phase", 32'(cycle_cnt), 32'(ph));
    endtask

    // Called with flush_stall observed high; counts stall cycles, then checks the single redirect.
    task automatic finish_flush(input string tag, input logic [31:0] exp_pc, input logic [1:0] exp_code,
                                input int exp_stall);
        int n = 0;
        while (flush_stall === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check_output({tag, " stall_len"}, n, exp_stall);
        check_output({tag, " redirect_vld"}, 32'(redirect_vld), 1);
        check_output({tag, " redirect_pc"}, redirect_pc, exp_pc);
        check_output({tag, " redirect_code"}, 32'(flush_code), 32'(exp_code));
        tick();
        check_output({tag, " redirect_once"}, 32'(redirect_vld), 0);
        check_output({tag, " busy_after"}, 32'(busy), 0);
    endtask

    task automatic do_flush(input string tag, input logic [2:0] exp_ack, input logic [1:0] exp_code,
                            input logic [31:0] exp_pc, input int exp_wait);
        int w;
        tick();
        check_output({tag, " ack"}, 32'({ack_trap, ack_jmp, ack_br}), 32'(exp_ack));
        check_output({tag, " busy"}, 32'(busy), 1);
        check_output({tag, " code"}, 32'(flush_code), 32'(exp_code));
        if (exp_ack[2]) trap_req = 1'b0;
        if (exp_ack[1]) jmp_req  = 1'b0;
        if (exp_ack[0]) br_req   = 1'b0;
        tick();
        w = 1;
        check_output({tag, " ack_pulse"}, 32'({ack_trap, ack_jmp, ack_br}), 0);
        while (flush_stall !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        check_output({tag, " phase_wait"}, w, exp_wait);
        finish_flush(tag, exp_pc, exp_code, FLUSH_CYC);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n;

        vecs[0] = '{trap: 1'b0, jmp: 1'b0, br: 1'b1, pc: 32'h0000_0100, phase: 4'd2,
                    exp_ack: 3'b001, exp_code: 2'd1, exp_wait: 3};
        vecs[1] = '{trap: 1'b0, jmp: 1'b1, br: 1'b0, pc: 32'h0000_0200, phase: 4'd4,
                    exp_ack: 3'b010, exp_code: 2'd1, exp_wait: 1};
        vecs[2] = '{trap: 1'b1, jmp: 1'b0, br: 1'b0, pc: 32'h0000_0008, phase: 4'd1,
                    exp_ack: 3'b100, exp_code: 2'd2, exp_wait: 4};
        vecs[3] = '{trap: 1'b0, jmp: 1'b0, br: 1'b1, pc: 32'hDEAD_BEEC, phase: 4'd3,
                    exp_ack: 3'b001, exp_code: 2'd1, exp_wait: 2};

        repeat (3) tick();
        check_output("reset busy", 32'(busy), 0);
        check_output("reset stall", 32'(flush_stall), 0);
        check_output("reset redirect", 32'(redirect_vld), 0);
        check_output("reset acks", 32'({ack_trap, ack_jmp, ack_br}), 0);
        hrst = 1'b0;
        phase_run = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            wait_phase(vecs[i].phase);
            apply_stimulus(vecs[i].trap, vecs[i].jmp, vecs[i].br, vecs[i].pc);
            do_flush($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_code, vecs[i].pc, vecs[i].exp_wait);
`ifdef EXU_FLUSH_PERF_EN
            if (i == 1) begin
                check_output("perf_flush_cnt", 32'(perf_flush_cnt), 2);
                check_output("perf_stall_cyc", 32'(perf_stall_cyc), 8);
            end
`endif
        end

        // All three sources at once: served trap, jump, branch in that order.
        wait_phase(4'd2);
        trap_req = 1'b1; trap_pc = 32'h8;
        jmp_req  = 1'b1; jmp_pc  = 32'h200;
        br_req   = 1'b1; br_pc   = 32'h300;
        do_flush("prio_trap", 3'b100, 2'd2, 32'h8, 3);
        do_flush("prio_jmp", 3'b010, 2'd1, 32'h200, 2);
        do_flush("prio_br", 3'b001, 2'd1, 32'h300, 2);

        // Trap preempts a branch flush with two stall cycles already spent.
        wait_phase(4'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        check_output("preempt ack_br", 32'({ack_trap, ack_jmp, ack_br}), 1);
        br_req = 1'b0;
        n = 0;
        while (flush_stall !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_output("preempt stall_start", n, 4);
        tick();
        check_output("preempt stall_2nd", 32'(flush_stall), 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h8);
        tick();
        check_output("preempt ack_trap", 32'({ack_trap, ack_jmp, ack_br}), 4);
        check_output("preempt stall_held", 32'(flush_stall), 1);
        check_output("preempt code", 32'(flush_code), 2);
        trap_req = 1'b0;
        finish_flush("preempt", 32'h8, 2'd2, FLUSH_CYC);

        // Reset mid-flush aborts without a redirect; the still-held jump is accepted again.
        wait_phase(4'd3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h200);
        tick();
        check_output("rst ack_jmp", 32'({ack_trap, ack_jmp, ack_br}), 2);
        n = 0;
        while (flush_stall !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tick();
        check_output("rst in_flush", 32'(flush_stall), 1);
        hrst = 1'b1;
        #1;
        check_output("rst stall", 32'(flush_stall), 0);
        check_output("rst busy", 32'(busy), 0);
        check_output("rst code", 32'(flush_code), 0);
        check_output("rst redirect", 32'(redirect_vld), 0);
        check_output("rst redirect_pc", redirect_pc, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_output("rst hold_redirect", 32'(redirect_vld), 0);
        end
        hrst = 1'b0;
        do_flush("rst_reaccept", 3'b010, 2'd1, 32'h200, ((4 - int'(cycle_cnt)) % 4) + 1);

        // Phase counter parked at 0: accepted flush must wait for cycle_cnt==1.
        phase_run = 1'b0;
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        check_output("zero_ph ack_br", 32'({ack_trap, ack_jmp, ack_br}), 1);
        br_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output("zero_ph no_stall", 32'(flush_stall), 0);
            check_output("zero_ph busy", 32'(busy), 1);
        end
        phase_run = 1'b1;
        tick();
        check_output("zero_ph still_wait", 32'(flush_stall), 0);
        tick();
        check_output("zero_ph stall_start", 32'(flush_stall), 1);
        finish_flush("zero_ph", 32'h100, 2'd1, FLUSH_CYC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
